// File: rtl/score_sequencer_pkg.sv
// score_sequencer_pkg: state encoding, score entry layout and shared constants
package score_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int SHIFT_MSB = 7;
    localparam int SHIFT_LSB = 6;
    localparam int NOTE_MSB  = 5;
    localparam int NOTE_LSB  = 3;
    localparam int DUR_MSB   = 2;
    localparam int DUR_LSB   = 0;

    localparam logic [2:0] END_MARKER_DUR = 3'd0;
    localparam logic [2:0] NOTE_REST      = 3'd0;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/score_sequencer_beat_timer.sv
// score_sequencer_beat_timer: loadable down-counter with enable and terminal-count pulse
module score_sequencer_beat_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    assign tc = en && cnt_q == W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: ROM-driven note sequencer for the tone generator; SCORE_LIVE_OVERRIDE_EN adds live_en/live_shift/live_note
module score_sequencer
    import score_sequencer_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [7:0]        rom_data,
    output logic [1:0]        shift,
    output logic [2:0]        note,
    output logic              tone_en,
    output logic              busy,
    output logic              done
`ifdef SCORE_LIVE_OVERRIDE_EN
    ,
    input  logic              live_en,
    input  logic [1:0]        live_shift,
    input  logic [2:0]        live_note
`endif
);

    localparam int TW = $clog2(max_int(7 * BEAT_CYCLES, GAP_CYCLES) + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [1:0]        ent_shift_q, ent_shift_d;
    logic [2:0]        ent_note_q, ent_note_d;
    logic [1:0]        shift_q, shift_d;
    logic [2:0]        note_q, note_d;
    logic              tone_q, tone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              t_load, t_en, t_tc;
    logic [TW-1:0]     t_val;
    logic              note_end, score_end, hold;
    logic [1:0]        rom_shift;
    logic [2:0]        rom_note, rom_dur;

    assign rom_shift = rom_data[SHIFT_MSB:SHIFT_LSB];
    assign rom_note  = rom_data[NOTE_MSB:NOTE_LSB];
    assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];

`ifdef SCORE_LIVE_OVERRIDE_EN
    assign hold = pause | live_en;
`else
    assign hold = pause;
`endif

    assign t_en = (state_q == S_PLAY || state_q == S_GAP) && !hold;

    score_sequencer_beat_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .tc       (t_tc)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        ent_shift_d = ent_shift_q;
        ent_note_d  = ent_note_q;
        t_load      = 1'b0;
        t_val       = '0;
        note_end    = 1'b0;
        score_end   = 1'b0;
        case (state_q)
            S_IDLE: if (start && !stop) begin
                state_d = S_FETCH;
                addr_d  = '0;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: if (rom_dur == END_MARKER_DUR) score_end = 1'b1;
            else begin
                ent_shift_d = rom_shift;
                ent_note_d  = rom_note;
                t_load      = 1'b1;
                t_val       = TW'(int'(rom_dur) * BEAT_CYCLES);
                state_d     = S_PLAY;
            end
            S_PLAY: if (t_tc) begin
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                    t_load  = 1'b1;
                    t_val   = TW'(GAP_CYCLES);
                end else note_end = 1'b1;
            end
            S_GAP: note_end = t_tc;
            default: state_d = S_IDLE;
        endcase
        if (note_end && addr_q != '1) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
        end
        // the last ROM address ends the score instead of wrapping
        if (score_end || (note_end && addr_q == '1)) begin
            addr_d  = '0;
            state_d = loop ? S_FETCH : S_IDLE;
            done_d  = !loop;
        end
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = '0;
            done_d  = 1'b0;
        end
        shift_d = state_d == S_PLAY ? ent_shift_d : 2'd0;
        note_d  = state_d == S_PLAY ? ent_note_d : NOTE_REST;
        tone_d  = state_d == S_PLAY && ent_note_d != NOTE_REST && !hold;
`ifdef SCORE_LIVE_OVERRIDE_EN
        if (live_en) begin
            shift_d = live_shift;
            note_d  = live_note;
            tone_d  = live_note != NOTE_REST;
        end
`endif
        rd_d   = state_d == S_FETCH;
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            ent_shift_q <= 2'd0;
            ent_note_q  <= NOTE_REST;
            shift_q     <= 2'd0;
            note_q      <= NOTE_REST;
            tone_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            ent_shift_q <= ent_shift_d;
            ent_note_q  <= ent_note_d;
            shift_q     <= shift_d;
            note_q      <= note_d;
            tone_q      <= tone_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign rom_rd   = rd_q;
    assign shift    = shift_q;
    assign note     = note_q;
    assign tone_en  = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: directed and randomized checks against a timeline model of the score player
module tb_score_sequencer;

    localparam int B  = 4;
    localparam int G  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [7:0]    rom_data = 8'd0;
    logic [1:0]    shift;
    logic [2:0]    note;
    logic          tone_en, busy, done;

    logic [7:0]  rom [8];
    logic [11:0] exp_q [$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    score_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .loop     (loop),
        .rom_addr (rom_addr),
        .rom_rd   (rom_rd),
        .rom_data (rom_data),
        .shift    (shift),
        .note     (note),
        .tone_en  (tone_en),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [11:0] obs();
        return {done, busy, rom_rd, tone_en, shift, note, rom_addr};
    endfunction

    function automatic logic [11:0] pk(input bit dn, input bit bz, input bit rd, input bit te,
                                       input logic [1:0] s, input logic [2:0] n, input logic [2:0] a);
        return {dn, bz, rd, te, s, n, a};
    endfunction

    function automatic logic [7:0] ent(input int s, input int n, input int d);
        return 8'((s << 6) | (n << 3) | d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int k = 0; k < 8; k++) rom[k] = 8'd0;
    endtask

    // expand the score into the expected per-cycle output timeline starting at the first FETCH
    task automatic build(input bit lp, input int len);
        int a = 0;
        int d;
        bit fin = 0;
        logic [7:0] e;
        exp_q.delete();
        while (exp_q.size() < len) begin
            if (fin) begin
                exp_q.push_back(12'd0);
                continue;
            end
            e = rom[a];
            d = int'(e[2:0]);
            exp_q.push_back(pk(0, 1, 1, 0, 2'd0, 3'd0, 3'(a)));
            exp_q.push_back(pk(0, 1, 0, 0, 2'd0, 3'd0, 3'(a)));
            if (d == 0) begin
                if (lp) a = 0;
                else begin
                    exp_q.push_back(pk(1, 0, 0, 0, 2'd0, 3'd0, 3'd0));
                    fin = 1;
                end
                continue;
            end
            repeat (d * B) exp_q.push_back(pk(0, 1, 0, e[5:3] != 0, e[7:6], e[5:3], 3'(a)));
            repeat (G) exp_q.push_back(pk(0, 1, 0, 0, 2'd0, 3'd0, 3'(a)));
            if (a == 7) begin
                if (lp) a = 0;
                else begin
                    exp_q.push_back(pk(1, 0, 0, 0, 2'd0, 3'd0, 3'd0));
                    fin = 1;
                end
            end else a++;
        end
    endtask

    task automatic run_trace(input string tag, input bit lp, input int len);
        build(lp, len);
        loop = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(exp_q[i]));
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        tick();
        chk({tag, "_idle"}, 32'(obs() >> 3), 32'd0);
    endtask

    initial begin
        int play_n, tone_n, done_n;
        clr();
        repeat (2) @(posedge clk);
        #3;
        chk("reset", 32'(obs()), 32'd0);
        rst_n = 1'b1;
        tick();

        clr();
        rom[0] = ent(1, 1, 2);
        run_trace("single", 1'b0, 25);

        clr();
        rom[0] = ent(0, 0, 1);
        rom[1] = ent(2, 5, 1);
        run_trace("rest", 1'b0, 30);

        clr();
        rom[0] = ent(1, 3, 1);
        rom[1] = ent(2, 7, 1);
        run_trace("loop", 1'b1, 60);

        for (int k = 0; k < 8; k++) rom[k] = ent(k % 4, k, 1 + k % 2);
        run_trace("eight", 1'b0, 100);

        clr();
        rom[0] = ent(1, 2, 3);
        play_n = 0;
        tone_n = 0;
        done_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 40; c++) begin
            pause = (c >= 6 && c < 11);
            tick();
            if (pause) chk("pause_tone", 32'(tone_en), 32'd0);
            play_n += int'(note != 3'd0);
            tone_n += int'(tone_en);
            done_n += int'(done);
        end
        pause = 1'b0;
        chk("pause_play_len", 32'(play_n), 32'(3 * B + 5));
        chk("pause_tone_len", 32'(tone_n), 32'(3 * B));
        chk("pause_done", 32'(done_n), 32'd1);
        chk("pause_busy", 32'(busy), 32'd0);

        clr();
        rom[0] = ent(1, 4, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("stop_pre_tone", 32'(tone_en), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_out", 32'(obs() >> 3), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("stop_quiet", 32'({done, busy, tone_en}), 32'd0);
        end

        start = 1'b1;
        stop = 1'b1;
        tick();
        chk("start_stop_0", 32'(obs() >> 3), 32'd0);
        tick();
        chk("start_stop_1", 32'(obs() >> 3), 32'd0);
        start = 1'b0;
        stop = 1'b0;
        tick();

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++)
                rom[k] = {8'($urandom_range(0, 31)) << 3} | 8'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3));
            run_trace($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 150);
        end

        clr();
        rom[0] = ent(2, 6, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("areset_pre_tone", 32'(tone_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_out", 32'(obs()), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("areset_after", 32'(obs()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
